// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: operation codes and controller states.
package seq_alu_pkg;

  localparam logic [1:0] OPC_ADD = 2'd0;
  localparam logic [1:0] OPC_SUB = 2'd1;
  localparam logic [1:0] OPC_MUL = 2'd2;
  localparam logic [1:0] OPC_DIV = 2'd3;

  typedef enum logic [1:0] {
    OP_ADD = OPC_ADD,
    OP_SUB = OPC_SUB,
    OP_MUL = OPC_MUL,
    OP_DIV = OPC_DIV
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_iter.sv
// One iteration of the shift-add multiplier or the restoring divider.
module seq_alu_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] opnd,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] acc_nxt,
  output logic             bit_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    sum     = {1'b0, acc} + {1'b0, b};
    shifted = {acc, opnd[WIDTH-1]};
    trial   = shifted - {1'b0, b};
    acc_nxt = acc;
    bit_nxt = 1'b0;
    if (op == OP_MUL) begin
      // bit_nxt is the product bit that drops into the top of the multiplier register
      if (opnd[0]) begin
        acc_nxt = sum[WIDTH:1];
        bit_nxt = sum[0];
      end else begin
        acc_nxt = {1'b0, acc[WIDTH-1:1]};
        bit_nxt = acc[0];
      end
    end else begin
      // remainder stays below b, so trial's top bit is a clean sign flag
      if (!trial[WIDTH]) begin
        acc_nxt = trial[WIDTH-1:0];
        bit_nxt = 1'b1;
      end else begin
        acc_nxt = shifted[WIDTH-1:0];
        bit_nxt = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ADD/SUB/MUL/DIV unit with valid/ready handshakes on both sides.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             zero,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH);

  state_e           state;
  op_e              op_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] opnd_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] opnd_nxt;
  logic             bit_nxt;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // bit WIDTH of sub_w is the borrow, i.e. a < b
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .acc     (acc_r),
    .opnd    (opnd_r),
    .b       (b_r),
    .op      (op_r),
    .acc_nxt (acc_nxt),
    .bit_nxt (bit_nxt)
  );

  // MUL shifts the multiplier right (product low half enters at the top);
  // DIV shifts the dividend left (quotient bits enter at the bottom).
  assign opnd_nxt = (op_r == OP_MUL) ? {bit_nxt, opnd_r[WIDTH-1:1]}
                                     : {opnd_r[WIDTH-2:0], bit_nxt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_r   <= OP_ADD;
      cnt    <= '0;
      acc_r  <= '0;
      opnd_r <= '0;
      b_r    <= '0;
      res_lo <= '0;
      res_hi <= '0;
      zero   <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_r   <= op_e'(op);
            acc_r  <= '0;
            opnd_r <= a;
            b_r    <= b;
            cnt    <= CW'(WIDTH - 1);
            dbz    <= 1'b0;
            case (op_e'(op))
              OP_ADD: begin
                res_lo <= add_w[WIDTH-1:0];
                res_hi <= {{(WIDTH-1){1'b0}}, add_w[WIDTH]};
                zero   <= (add_w == '0);
                state  <= DONE;
              end
              OP_SUB: begin
                res_lo <= sub_w[WIDTH-1:0];
                res_hi <= {{(WIDTH-1){1'b0}}, sub_w[WIDTH]};
                zero   <= (sub_w == '0);
                state  <= DONE;
              end
              OP_MUL: state <= RUN;
              default: begin
                if (b == '0) begin
                  res_lo <= '0;
                  res_hi <= '0;
                  zero   <= 1'b1;
                  dbz    <= 1'b1;
                  state  <= DONE;
                end else begin
                  state  <= RUN;
                end
              end
            endcase
          end
        end
        RUN: begin
          acc_r  <= acc_nxt;
          opnd_r <= opnd_nxt;
          if (cnt == '0) begin
            res_lo <= opnd_nxt;
            res_hi <= acc_nxt;
            zero   <= (opnd_nxt == '0) && (acc_nxt == '0);
            state  <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=8 and WIDTH=16.
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv8, ir8, ov8, ordy8, z8, d8;
  logic [1:0] op8;
  logic [7:0] a8, b8, lo8, hi8;

  logic        iv16, ir16, ov16, ordy16, z16, d16;
  logic [1:0]  op16;
  logic [15:0] a16, b16, lo16, hi16;

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .op(op8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(ordy8), .res_lo(lo8), .res_hi(hi8), .zero(z8), .dbz(d8)
  );

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .op(op16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(ordy16), .res_lo(lo16), .res_hi(hi16), .zero(z16), .dbz(d16)
  );

  logic        sel16;
  logic [31:0] lo_o, hi_o;
  logic        ov_o, ir_o, z_o, d_o;
  assign lo_o = sel16 ? {16'b0, lo16} : {24'b0, lo8};
  assign hi_o = sel16 ? {16'b0, hi16} : {24'b0, hi8};
  assign ov_o = sel16 ? ov16 : ov8;
  assign ir_o = sel16 ? ir16 : ir8;
  assign z_o  = sel16 ? z16 : z8;
  assign d_o  = sel16 ? d16 : d8;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    longint unsigned m  = (64'd1 << w) - 1;
    longint unsigned la = a;
    longint unsigned lb = b;
    longint unsigned r;
    exp_t e;
    e.dbz = 1'b0;
    e.lat = 1;
    case (op)
      2'd0: begin
        r    = la + lb;
        e.lo = 32'(r & m);
        e.hi = 32'(r >> w);
      end
      2'd1: begin
        r    = (la + m + 1 - lb) & m;
        e.lo = 32'(r);
        e.hi = (la < lb) ? 32'd1 : 32'd0;
      end
      2'd2: begin
        r     = la * lb;
        e.lo  = 32'(r & m);
        e.hi  = 32'(r >> w);
        e.lat = w + 1;
      end
      default: begin
        if (lb == 0) begin
          e.lo  = 0;
          e.hi  = 0;
          e.dbz = 1'b1;
        end else begin
          e.lo  = 32'(la / lb);
          e.hi  = 32'(la % lb);
          e.lat = w + 1;
        end
      end
    endcase
    e.z = (e.lo == 0) && (e.hi == 0);
    return e;
  endfunction

  task automatic drive(input bit w16, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    if (w16) begin
      iv16 = 1'b1; op16 = op; a16 = a[15:0]; b16 = b[15:0];
    end else begin
      iv8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  task automatic run_op(input bit w16, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    exp_t e;
    int   lat;
    sel16 = w16;
    sb.push_back(model(w16 ? 16 : 8, op, a, b));
    @(negedge clk);
    chk("in_ready_idle", ir_o, 1);
    drive(w16, op, a, b);
    @(posedge clk);
    #1;
    // inputs must be ignored once the request has been taken
    iv8 = 1'b0; iv16 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
    op8 = 2'($urandom); op16 = 2'($urandom);
    lat = 1;
    while (!ov_o && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("res_lo", lo_o, e.lo);
    chk("res_hi", hi_o, e.hi);
    chk("zero", z_o, e.z);
    chk("dbz", d_o, e.dbz);
    chk("in_ready_done", ir_o, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", ov_o, 1);
      chk("hold_ready", ir_o, 0);
      chk("hold_lo", lo_o, e.lo);
      chk("hold_hi", hi_o, e.hi);
    end
    @(negedge clk);
    ordy8 = 1'b1; ordy16 = 1'b1;
    @(posedge clk);
    #1;
    ordy8 = 1'b0; ordy16 = 1'b0;
    chk("out_valid_drop", ov_o, 0);
    chk("in_ready_back", ir_o, 1);
  endtask

  initial begin
    rst = 1'b1;
    iv8 = 0; op8 = 0; a8 = 0; b8 = 0; ordy8 = 0;
    iv16 = 0; op16 = 0; a16 = 0; b16 = 0; ordy16 = 0;
    sel16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", ir8, 1);
    chk("rst_out_valid", ov8, 0);
    chk("rst_lo", lo8, 0);
    chk("rst_hi", hi8, 0);
    chk("rst_zero", z8, 0);
    chk("rst_dbz", d8, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(0, 2'd0, 200, 100, 0);
    run_op(0, 2'd1, 5, 7, 0);
    run_op(0, 2'd1, 9, 9, 0);
    run_op(0, 2'd2, 255, 255, 5);
    run_op(0, 2'd3, 200, 7, 0);
    run_op(0, 2'd3, 9, 0, 2);
    run_op(1, 2'd2, 32'hFFFF, 32'hFFFF, 0);
    run_op(1, 2'd3, 32'hFFFF, 32'h0003, 0);
    run_op(0, 2'd3, 7, 200, 0);
    run_op(0, 2'd0, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      bit w = i[0];
      run_op(w, 2'($urandom_range(0, 3)), $urandom & (w ? 32'hFFFF : 32'hFF),
             $urandom & (w ? 32'hFFFF : 32'hFF), i % 3);
    end

    // abort a MUL during its 4th iteration
    sel16 = 1'b0;
    @(negedge clk);
    drive(0, 2'd2, 200, 150);
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", ov8, 0);
    chk("abort_lo", lo8, 0);
    chk("abort_hi", hi8, 0);
    chk("abort_in_ready", ir8, 1);
    @(negedge clk);
    drive(0, 2'd0, 3, 4);
    @(posedge clk);
    #1;
    chk("rst_ignores_valid", ov8, 0);
    @(negedge clk);
    iv8 = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", ir8, 1);
    chk("post_rst_out_valid", ov8, 0);
    run_op(0, 2'd0, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle arithmetic unit that generalises the team's 8-bit combinational add/subtract/multiply/divide cells. It supports any operand width and performs ADD, SUB, MUL and DIV (quotient and remainder) behind a valid/ready handshake. MUL uses an iterative shift-add datapath and DIV uses a restoring datapath, so area stays flat as WIDTH grows. It sits between the instruction decode logic and the register write-back path. It accepts one operation at a time.

## Interface
- WIDTH, default 8: operand width in bits; legal range 2..32.
- clk  in  1: single clock, rising edge.
- rst  in  1: reset, asynchronous, active-high.
- in_valid  in  1: operation request.
- in_ready  out  1: block can accept a request; high only in IDLE.
- op  in  2: operation code; ADD=0, SUB=1, MUL=2, DIV=3.
- a  in  WIDTH: first operand, unsigned.
- b  in  WIDTH: second operand, unsigned.
- out_valid  out  1: result available; high only in DONE.
- out_ready  in  1: consumer accepts the result.
- res_lo  out  WIDTH: ADD/SUB result, MUL low half, or DIV quotient.
- res_hi  out  WIDTH: ADD carry or SUB borrow in bit 0 (other bits 0), MUL high half, or DIV remainder.
- zero  out  1: res_lo and res_hi are both 0.
- dbz  out  1: a DIV had b==0.

## Operation
- States:
  - IDLE: waits for a request.
  - RUN: performs the MUL/DIV iterations.
  - DONE: holds the result until the consumer takes it.
- Accept: a request is accepted on a rising edge where in_valid && in_ready. On that edge, a, b and op are registered. Inputs are ignored at all other times.
- ADD: {carry, sum} = a + b, computed at full WIDTH+1 precision. The block goes IDLE→DONE directly.
- SUB: res_lo = a − b modulo 2^WIDTH, and res_hi[0] = (a < b). The block goes IDLE→DONE directly.
- MUL: 2·WIDTH-bit product via WIDTH shift-add iterations in RUN, one per cycle. An iteration counter runs from WIDTH−1 down to 0.
- DIV: WIDTH restoring-division iterations in RUN, one per cycle.
- Division by zero (DIV with b==0): the iteration is skipped. The block goes IDLE→DONE with res_lo=0, res_hi=0 and dbz=1.
- dbz is 0 for every other operation.
- From RUN, the block moves to DONE on the edge that completes the final iteration.
- DONE: all outputs stay stable while out_ready is low. The block returns to IDLE on the edge where out_valid && out_ready.
- No new request can be accepted in the same cycle as the output handshake, because in_ready is low in DONE.
- An illegal op cannot occur; the 2-bit encoding is fully decoded.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, res_lo=0, res_hi=0, zero=0, dbz=0, and the iteration counter is 0.
- Reset applies immediately on assertion of rst, not on the next clock edge.
- While rst is high, in_valid is ignored.
- Reset asserted mid-RUN or in DONE aborts the operation and discards the result. No partial result is ever presented.
- Latency is counted from the accept edge to the edge that raises out_valid:
  - ADD, SUB, and DIV by zero: 1 edge.
  - MUL and DIV: WIDTH+1 edges (one load edge plus WIDTH iteration edges).
- Throughput: at most one operation per (latency + 1) cycles, because the output handshake edge also returns the block to IDLE.
- All outputs are registered. in_ready and out_valid are decoded directly from the state register.

## Structure
- Shared package seq_alu_pkg holds:
  - the op_e enum (ADD, SUB, MUL, DIV);
  - the state_e enum (IDLE, RUN, DONE);
  - the op-code constants.
- Sub-module seq_alu_iter holds the combinational datapath for one MUL/DIV iteration step:
  - inputs: partial accumulator, shifted operand, op select;
  - outputs: next accumulator, next quotient bit.
- The top level owns the state machine, the counter, the handshake logic and the result registers.

## Test plan
- ADD with WIDTH=8, a=200, b=100 → res_lo=0x2C, res_hi=0x01, zero=0; out_valid exactly 1 edge after accept.
- SUB with a=5, b=7 → res_lo=0xFE, res_hi=0x01; SUB with a=9, b=9 → res_lo=0, res_hi=0, zero=1.
- MUL with a=255, b=255 → res_hi=0xFE, res_lo=0x01, out_valid exactly 9 edges after accept. With WIDTH=16, a=0xFFFF, b=0xFFFF → res_hi=0xFFFE, res_lo=0x0001 after 17 edges.
- DIV with a=200, b=7 → res_lo=28, res_hi=4, dbz=0 after 9 edges. DIV with a=9, b=0 → res_lo=0, res_hi=0, dbz=1 after 1 edge.
- Backpressure: hold out_ready low for 5 cycles after a MUL completes → outputs stable, in_ready stays 0. Then raise out_ready → IDLE and in_ready=1 on the next edge, and the next request is accepted.
- Assert rst asynchronously during the 4th MUL iteration → out_valid=0 and res=0 immediately. After release, in_ready=1, and an ADD with a=1, b=1 returns res_lo=2.
